// File: rtl/atr_gpio_mux_if.sv
// rtl/atr_gpio_mux_if.sv - register write strobe bus for atr_gpio_mux
interface atr_gpio_mux_if;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (
    output wr_stb,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_stb,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/atr_gpio_mux.sv
// rtl/atr_gpio_mux.sv - ATR flag to GPIO pattern mux with break-before-make guard
module atr_gpio_mux #(
  parameter int WIDTH   = 16,
  parameter int GUARD_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic               atr_tx_i,
  atr_gpio_mux_if.slave      reg_if,
  input  logic [WIDTH-1:0]   gpio_manual_i,
  output logic [WIDTH-1:0]   gpio_o,
  output logic [1:0]         atr_state_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_RX    = 2'b00,
    ST_GUARD = 2'b01,
    ST_TX    = 2'b10
  } state_e;

  localparam logic [GUARD_W-1:0] GUARD_ONE  = 1;
  localparam logic [GUARD_W-1:0] GUARD_ZERO = 0;

  state_e             state_q;
  logic [GUARD_W-1:0] cnt_q;

  logic [WIDTH-1:0]   rx_pat_q;
  logic [WIDTH-1:0]   tx_pat_q;
  logic [WIDTH-1:0]   idle_pat_q;
  logic [WIDTH-1:0]   atr_mask_q;
  logic [GUARD_W-1:0] guard_q;

  logic [WIDTH-1:0]   wr_pat;
  logic [GUARD_W-1:0] wr_guard;
  logic [WIDTH-1:0]   atr_pat;
  logic [WIDTH-1:0]   gpio_q;

  // Fit the fixed 16-bit write data to the pattern and guard widths.
  generate
    if (WIDTH > 16) begin : g_pat_ext
      assign wr_pat = {{(WIDTH - 16){1'b0}}, reg_if.wr_data};
    end else begin : g_pat_trunc
      assign wr_pat = reg_if.wr_data[WIDTH-1:0];
    end
    if (GUARD_W > 16) begin : g_guard_ext
      assign wr_guard = {{(GUARD_W - 16){1'b0}}, reg_if.wr_data};
    end else begin : g_guard_trunc
      assign wr_guard = reg_if.wr_data[GUARD_W-1:0];
    end
  endgenerate

  // Register file; addresses 5-7 are decoded to nothing so writes there are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_pat_q   <= '0;
      tx_pat_q   <= '0;
      idle_pat_q <= '0;
      atr_mask_q <= '0;
      guard_q    <= '0;
    end else if (reg_if.wr_stb) begin
      case (reg_if.wr_addr)
        3'd0:    rx_pat_q   <= wr_pat;
        3'd1:    tx_pat_q   <= wr_pat;
        3'd2:    idle_pat_q <= wr_pat;
        3'd3:    atr_mask_q <= wr_pat;
        3'd4:    guard_q    <= wr_guard;
        default: ;
      endcase
    end
  end

  // RX/GUARD/TX sequencer; guard length is latched into cnt on entry so a
  // mid-interval guard rewrite only affects the next transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
    end else if (!ena_i) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RX: begin
          if (atr_tx_i) begin
            if (guard_q == GUARD_ZERO) begin
              state_q <= ST_TX;
            end else begin
              state_q <= ST_GUARD;
              cnt_q   <= guard_q - GUARD_ONE;
            end
          end
        end
        ST_TX: begin
          if (!atr_tx_i) begin
            if (guard_q == GUARD_ZERO) begin
              state_q <= ST_RX;
            end else begin
              state_q <= ST_GUARD;
              cnt_q   <= guard_q - GUARD_ONE;
            end
          end
        end
        ST_GUARD: begin
          // Target is chosen only on the exit cycle; atr_tx_i activity
          // inside the interval neither restarts nor extends it.
          if (cnt_q != GUARD_ZERO) begin
            cnt_q <= cnt_q - GUARD_ONE;
          end else begin
            state_q <= atr_tx_i ? ST_TX : ST_RX;
          end
        end
        default: begin
          state_q <= ST_RX;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Pattern selected by the current state; idle pattern while guarding.
  always_comb begin
    atr_pat = rx_pat_q;
    case (state_q)
      ST_GUARD: atr_pat = idle_pat_q;
      ST_TX:    atr_pat = tx_pat_q;
      default:  atr_pat = rx_pat_q;
    endcase
  end

  // Pin drive: masked bits follow the ATR pattern, the rest follow software.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= (atr_pat & atr_mask_q) | (gpio_manual_i & ~atr_mask_q);
    end
  end

  assign gpio_o      = gpio_q;
  assign atr_state_o = state_q;
  assign busy_o      = (state_q == ST_GUARD);

endmodule
